mem_wb_stage: RTL and testbench

- Memory-access stage of the MIPS pipeline: word-addressed data memory plus the MEM/WB pipeline register.
- Consumes EX/MEM signals (ALU result, store data, control bits).
- Produces registered ALUresult/DMresult/memtoReg/regWrite/writeReg that feed the writeback select mux, and on to the register file.
- Handles stall, flush, and address-error detection.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mem_wb_stage_if.sv | 32 +++
 rtl/mem_wb_stage_data_mem.sv | 44 ++++
 rtl/mem_wb_stage.sv | 71 +++++++
 tb/tb_mem_wb_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants used by the MEM stage and its neighbours.
package mips_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned REG_W        = 5;
  localparam logic [31:0] DM_BASE_ADDR = 32'h10010000;

  typedef struct packed {
    logic memRead;
    logic memWrite;
    logic memtoReg;
    logic regWrite;
  } exmem_ctrl_t;

  typedef struct packed {
    logic              memtoReg;
    logic              regWrite;
    logic [REG_W-1:0]  writeReg;
    logic [DATA_W-1:0] ALUresult;
    logic [DATA_W-1:0] DMresult;
    logic              addrErr;
  } memwb_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory-access stage, bundled as one interface.
interface mem_wb_stage_if;
  import mips_pkg::*;

  logic              stall;
  logic              flush;
  logic              memRead;
  logic              memWrite;
  logic              memtoReg;
  logic              regWrite;
  logic [REG_W-1:0]  writeReg;
  logic [DATA_W-1:0] ALUresult;
  logic [DATA_W-1:0] writeData;

  logic              memtoReg_wb;
  logic              regWrite_wb;
  logic [REG_W-1:0]  writeReg_wb;
  logic [DATA_W-1:0] ALUresult_wb;
  logic [DATA_W-1:0] DMresult_wb;
  logic              addrErr_wb;

  modport master (
    output stall, flush, memRead, memWrite, memtoReg, regWrite, writeReg, ALUresult, writeData,
    input  memtoReg_wb, regWrite_wb, writeReg_wb, ALUresult_wb, DMresult_wb, addrErr_wb
  );

  modport slave (
    input  stall, flush, memRead, memWrite, memtoReg, regWrite, writeReg, ALUresult, writeData,
    output memtoReg_wb, regWrite_wb, writeReg_wb, ALUresult_wb, DMresult_wb, addrErr_wb
  );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: address decode, gated synchronous write, asynchronous read
// and address-error detection.
module data_mem
  import mips_pkg::*;
#(
  parameter int unsigned      DEPTH     = 1024,
  parameter logic [DATA_W-1:0] BASE_ADDR = DM_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wr_allow,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err
);

  localparam int unsigned       AW   = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] Span = DATA_W'(DEPTH) << 2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] off;
  logic [AW-1:0]     idx;
  logic              valid;
  logic              we;

  // Addresses below the base wrap to huge offsets and fail the range check.
  assign off   = addr - BASE_ADDR;
  assign idx   = off[AW+1:2];
  assign valid = (off[1:0] == 2'b00) && (off < Span);

  assign addr_err = ((mem_read | mem_write) & ~valid) | (mem_read & mem_write);
  assign we       = mem_write & valid & ~mem_read & wr_allow & rst_n;
  assign rdata    = (mem_read & valid & ~mem_write) ? mem_q[idx] : '0;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage: data memory plus the MEM/WB pipeline register with stall,
// flush and address-error gating of the register write.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [DATA_W-1:0] BASE_ADDR = DM_BASE_ADDR
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  exmem_ctrl_t       ctrl;
  memwb_t            wb_d, wb_q;
  logic [DATA_W-1:0] rdata;
  logic              addr_err;

  assign ctrl = '{
    memRead:  bus.memRead,
    memWrite: bus.memWrite,
    memtoReg: bus.memtoReg,
    regWrite: bus.regWrite
  };

  data_mem #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_data_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_read (ctrl.memRead),
    .mem_write(ctrl.memWrite),
    .wr_allow (~bus.stall & ~bus.flush),
    .addr     (bus.ALUresult),
    .wdata    (bus.writeData),
    .rdata    (rdata),
    .addr_err (addr_err)
  );

  always_comb begin
    wb_d = wb_q;
    if (bus.flush) begin
      wb_d = '0;
    end else if (!bus.stall) begin
      wb_d.memtoReg  = ctrl.memtoReg;
      // A faulting load must not write garbage into the register file.
      wb_d.regWrite  = ctrl.regWrite & ~(ctrl.memRead & addr_err);
      wb_d.writeReg  = bus.writeReg;
      wb_d.ALUresult = bus.ALUresult;
      wb_d.DMresult  = rdata;
      wb_d.addrErr   = addr_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign bus.memtoReg_wb  = wb_q.memtoReg;
  assign bus.regWrite_wb  = wb_q.regWrite;
  assign bus.writeReg_wb  = wb_q.writeReg;
  assign bus.ALUresult_wb = wb_q.ALUresult;
  assign bus.DMresult_wb  = wb_q.DMresult;
  assign bus.addrErr_wb   = wb_q.addrErr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// compared every cycle against a word-array reference model.
module tb_mem_wb_stage;
  import mips_pkg::*;

  localparam int unsigned Depth = 1024;
  localparam logic [31:0] Base  = 32'h10010000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage #(
    .DEPTH    (Depth),
    .BASE_ADDR(Base)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain word array with a written-flag per word.
  logic [31:0] mdl_mem   [Depth];
  bit          mdl_known [Depth];
  logic        e_m2r, e_rw, e_err;
  logic [4:0]  e_wreg;
  logic [31:0] e_alu, e_dm;
  bit          e_dm_known = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] off;
    int          w;
    bit          ok, err;
    if (!rst_n) begin
      {e_m2r, e_rw, e_err, e_wreg, e_alu, e_dm} = '0;
      e_dm_known = 1'b1;
    end else begin
      off = bus.ALUresult - Base;
      ok  = (off % 4 == 0) && (off < Depth * 4);
      w   = int'(off / 4) % Depth;
      err = ((bus.memRead || bus.memWrite) && !ok) || (bus.memRead && bus.memWrite);
      if (bus.flush) begin
        {e_m2r, e_rw, e_err, e_wreg, e_alu, e_dm} = '0;
        e_dm_known = 1'b1;
      end else if (!bus.stall) begin
        e_m2r  = bus.memtoReg;
        e_wreg = bus.writeReg;
        e_alu  = bus.ALUresult;
        e_err  = err;
        e_rw   = bus.regWrite && !(bus.memRead && err);
        if (bus.memRead && !err) begin
          e_dm       = mdl_mem[w];
          e_dm_known = mdl_known[w];
        end else begin
          e_dm       = '0;
          e_dm_known = 1'b1;
        end
      end
      if (bus.memWrite && !bus.memRead && ok && !bus.stall && !bus.flush) begin
        mdl_mem[w]   = bus.writeData;
        mdl_known[w] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("memtoReg_wb", 32'(bus.memtoReg_wb), 32'(e_m2r));
      chk("regWrite_wb", 32'(bus.regWrite_wb), 32'(e_rw));
      chk("writeReg_wb", 32'(bus.writeReg_wb), 32'(e_wreg));
      chk("ALUresult_wb", bus.ALUresult_wb, e_alu);
      chk("addrErr_wb", 32'(bus.addrErr_wb), 32'(e_err));
      if (e_dm_known) chk("DMresult_wb", bus.DMresult_wb, e_dm);
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] wd,
                       input logic st, input logic fl);
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.memtoReg  = m2r;
    bus.regWrite  = rw;
    bus.writeReg  = wreg;
    bus.ALUresult = alu;
    bus.writeData = wd;
    bus.stall     = st;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic st);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, a, d, st, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r);
    issue(1'b1, 1'b0, 1'b1, 1'b1, r, a, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " memtoReg"}, 32'(bus.memtoReg_wb), 32'd0);
    chk({tag, " regWrite"}, 32'(bus.regWrite_wb), 32'd0);
    chk({tag, " writeReg"}, 32'(bus.writeReg_wb), 32'd0);
    chk({tag, " ALUresult"}, bus.ALUresult_wb, 32'd0);
    chk({tag, " DMresult"}, bus.DMresult_wb, 32'd0);
    chk({tag, " addrErr"}, 32'(bus.addrErr_wb), 32'd0);
  endtask

  task automatic mid_cycle_reset();
    #3 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] fib [12] = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21,
                            32'd34, 32'd55, 32'd89, 32'd144};

  initial begin
    issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_all_zero("post reset");

    // ALU pass-through, then an asynchronous reset while outputs are non-zero.
    issue(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h00FF, 32'd0, 1'b0, 1'b0);
    chk("pass ALUresult", bus.ALUresult_wb, 32'h00FF);
    chk("pass writeReg", 32'(bus.writeReg_wb), 32'd8);
    chk("pass DMresult", bus.DMresult_wb, 32'd0);
    chk("pass memtoReg", 32'(bus.memtoReg_wb), 32'd0);
    mid_cycle_reset();

    for (int i = 0; i < 12; i++) store(Base + 32'(i * 4), fib[i], 1'b0);
    for (int i = 0; i < 12; i++) begin
      load(Base + 32'(i * 4), 5'(i + 1));
      chk("fib DMresult", bus.DMresult_wb, fib[i]);
      chk("fib regWrite", 32'(bus.regWrite_wb), 32'd1);
      chk("fib addrErr", 32'(bus.addrErr_wb), 32'd0);
    end

    load(Base + 32'h2, 5'd9);
    chk("misaligned addrErr", 32'(bus.addrErr_wb), 32'd1);
    chk("misaligned DMresult", bus.DMresult_wb, 32'd0);
    chk("misaligned regWrite", 32'(bus.regWrite_wb), 32'd0);

    store(32'h10011000, 32'hBADBAD, 1'b0);
    chk("oob store addrErr", 32'(bus.addrErr_wb), 32'd1);
    load(Base, 5'd2);
    chk("oob store no alias", bus.DMresult_wb, 32'd1);

    store(Base + 32'h40, 32'h1111, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, Base + 32'h40, 32'hDEAD, 1'b1, 1'b0);
    chk("stall holds writeReg", 32'(bus.writeReg_wb), 32'd0);
    chk("stall holds ALUresult", bus.ALUresult_wb, Base + 32'h40);
    load(Base + 32'h40, 5'd4);
    chk("stalled store blocked", bus.DMresult_wb, 32'h1111);
    store(Base + 32'h40, 32'hDEAD, 1'b0);
    load(Base + 32'h40, 5'd4);
    chk("unstalled store", bus.DMresult_wb, 32'hDEAD);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, Base + 32'h40, 32'd0, 1'b1, 1'b1);
    check_all_zero("flush+stall");
    load(Base + 32'h40, 5'd4);
    chk("flush blocks nothing", bus.DMresult_wb, 32'hDEAD);

    store(Base + 32'h8, 32'h77, 1'b0);
    load(Base + 32'h8, 5'd5);
    chk("store->load fwd", bus.DMresult_wb, 32'h77);

    // Randomized traffic over a small window plus invalid addresses.
    for (int n = 0; n < 400; n++) begin
      int unsigned kind, op;
      logic [31:0] a;
      logic        rd, wr;
      kind = $urandom_range(0, 9);
      op   = $urandom_range(0, 9);
      a    = Base + 32'($urandom_range(0, 15) * 4);
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = ($urandom_range(0, 1) == 1) ? Base + 32'h1000 + a[5:0] : Base - 4;
      rd = (op <= 3) || (op == 7);
      wr = (op >= 4 && op <= 7);
      issue(rd, wr, 1'($urandom), 1'($urandom), 5'($urandom), a, $urandom,
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      if (n == 200) mid_cycle_reset();
    end

    issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
